lu_arbiter: RTL and testbench
=============================

# lu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit bitwise logic unit (AND/OR/XOR/NOR) in the MiniMIPS datapath.
- Accepts operations from the integer execute stage (port 0) and the branch/compare helper (port 1) over valid/ready handshakes.
- Grants one requester per cycle using round-robin priority.
- Drives the shared unit and returns the registered result, tagged with the requester ID, through a one-entry output buffer.

## Interface
Parameters:
- WIDTH, 32: operand and result width.

Ports:
- clk  input  1  rising-edge clock; the block uses a single clock.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  port 0 has an operation.
- req0_ready  output  1  port 0 operation accepted this cycle.
- req0_op  input  2  operation select: 00 AND, 01 OR, 10 XOR, 11 NOR.
- req0_a, req0_b  input  WIDTH  port 0 operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as port 0, for port 1.
- resp_valid  output  1  result buffer full.
- resp_ready  input  1  consumer takes the result this cycle.
- resp_id  output  1  requester that issued the result.
- resp_data  output  WIDTH  result.
- resp_zero  output  1  result is all zeros. Present only when LU_ZERO_FLAG_EN is defined.

## Operation
State machine, two states: EMPTY and FULL (FULL ≡ resp_valid).

Slot availability:
- `can_accept = !resp_valid || resp_ready`. The slot is free when empty, or when it is being drained in the same cycle.

Grant:
- Computed only when `can_accept` is 1.
- If only one valid is high, that port wins.
- If both are high, the port named by `prio` wins. `prio` is a 1-bit register, reset value 0.
- On every grant, `prio` is set to the non-winning port.
- The ready signal of the granted port is 1, combinationally, in the grant cycle. The other port's ready is 0.

Capture:
- On the grant edge, `resp_data` ← op(a, b), `resp_id` ← winner, and the state becomes FULL.

Drain:
- If FULL, `resp_ready` is 1, and there is no grant, the state becomes EMPTY.
- If FULL, `resp_ready` is 1, and there is a grant, the state stays FULL with the new contents (back-to-back transfer, no bubble).

Hold:
- While FULL and `resp_ready` is 0, `resp_data`, `resp_id`, and `resp_zero` are stable.
- In this condition both ready outputs are 0.

NOR is computed as the bitwise complement of OR over all WIDTH bits. No carry and no width growth.

Requester obligations:
- A requester keeps valid and its operands stable until it sees ready. The block does not check this.

## Timing
- Latency: request accepted at edge N gives `resp_valid` high after edge N. The result is visible in cycle N+1.
- Throughput: one operation per cycle when `resp_ready` is held high.
- The ready outputs depend combinationally on the valid inputs, `resp_valid`, `resp_ready`, and `prio`. There is no combinational path from the operand inputs to any output.

Reset values (after reset):
- `resp_valid` = 0, `resp_id` = 0, `resp_data` = 0, `resp_zero` = 0, `prio` = 0.
- State = EMPTY.
- Both ready outputs are 0 while reset is high.

Reset mid-operation:
- A result held in FULL is discarded. No response is produced for it.
- A request presented while reset is high is not accepted.

Boundary cases:
- Both ports valid with the slot full and not draining: no grant, and `prio` is unchanged.
- Both ports valid on consecutive cycles: grants alternate 0,1,0,1…

## Configuration
Macro: `LU_ZERO_FLAG_EN`.
- Defined: the `resp_zero` port exists. It is registered alongside `resp_data` as (result == 0).
- Undefined: the port and its register are omitted. All other behaviour is identical.

## Structure
Shared package `lu_pkg` holds:
- the 2-bit op typedef and its encodings LU_AND, LU_OR, LU_XOR, LU_NOR;
- the state typedef with values EMPTY and FULL.

Sub-module `logic32`: the combinational WIDTH-bit AND/OR/XOR/NOR unit with an op select. It is instantiated once and fed from the granted port's multiplexed operands.

## Test plan
1. Reset, then port 0 sends OR with a=0x0000_F0F0, b=0x0F0F_0000, `resp_ready`=1.
   - `req0_ready`=1 in the grant cycle.
   - Next cycle: `resp_valid`=1, `resp_data`=0x0F0F_F0F0, `resp_id`=0.
2. Both ports valid continuously, `resp_ready`=1.
   - Grants go 0,1,0,1 over four cycles.
   - `resp_id` follows one cycle later.
3. Hold `resp_ready`=0 with the slot full while both ports are valid.
   - Both readies stay 0.
   - Data is stable for 5 cycles.
   - Raising `resp_ready` drains the slot and grants in the same cycle (no bubble).
4. Port 1 sends NOR with a=0, b=0.
   - Result is 0xFFFF_FFFF.
   - With `LU_ZERO_FLAG_EN` defined: `resp_zero`=0. A following AND with a=0xFFFF_0000, b=0x0000_FFFF gives 0 and `resp_zero`=1.
5. Assert reset while FULL with `resp_ready`=0.
   - Next cycle: `resp_valid`=0, `prio`=0.
   - No stale response appears afterwards.

Source files
------------

// File: rtl/lu_pkg.sv
// Shared definitions for the logic-unit arbiter.
//   lu_op_t    : 2-bit operation select (AND, OR, XOR, NOR)
//   lu_state_t : output-buffer state (EMPTY, FULL)
package lu_pkg;

    typedef enum logic [1:0] {
        LU_AND = 2'b00,
        LU_OR  = 2'b01,
        LU_XOR = 2'b10,
        LU_NOR = 2'b11
    } lu_op_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } lu_state_t;

endpackage

// File: rtl/logic32.sv
// Combinational WIDTH-bit bitwise logic unit.
// Ports:
//   op : operation select (lu_op_t)
//   a  : operand A
//   b  : operand B
//   y  : op(a, b); NOR is the complement of OR over every bit
module logic32
    import lu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  lu_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign y[gi] = (op == LU_AND) ? (a[gi] & b[gi]) :
                           (op == LU_OR)  ? (a[gi] | b[gi]) :
                           (op == LU_XOR) ? (a[gi] ^ b[gi]) :
                                            ~(a[gi] | b[gi]);
        end
    endgenerate

endmodule

// File: rtl/lu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared bitwise logic unit,
// returning the registered result through a one-entry output buffer.
// Ports:
//   clk, reset                      : clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b (N=0,1) : request handshakes and operands
//   resp_valid/ready                : result buffer handshake
//   resp_id, resp_data              : requester ID and result
//   resp_zero                       : result == 0 (only with LU_ZERO_FLAG_EN)
// Optional feature macro: LU_ZERO_FLAG_EN adds the resp_zero port and register.
module lu_arbiter
    import lu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             resp_id,
    output logic [WIDTH-1:0] resp_data
`ifdef LU_ZERO_FLAG_EN
    ,
    output logic             resp_zero
`endif
);

    lu_state_t        state_reg, state_next;
    logic             prio_reg, prio_next;
    logic             id_reg;
    logic [WIDTH-1:0] data_reg;

    logic             can_accept;
    logic             grant_valid;
    logic             grant_id;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [WIDTH-1:0] lu_result;

    // Operand mux driven only by the grant decision, so operands never reach
    // any output combinationally.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_mux
            assign sel_a[gi] = grant_id ? req1_a[gi] : req0_a[gi];
            assign sel_b[gi] = grant_id ? req1_b[gi] : req0_b[gi];
        end
    endgenerate
    assign sel_op = grant_id ? req1_op : req0_op;

    logic32 #(.WIDTH(WIDTH)) u_logic32 (
        .op (lu_op_t'(sel_op)),
        .a  (sel_a),
        .b  (sel_b),
        .y  (lu_result)
    );

    always_comb begin
        can_accept  = 1'b0;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        prio_next   = prio_reg;
        state_next  = state_reg;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;

        // Reset masks the grant so nothing is accepted while it is high.
        can_accept = !reset && ((state_reg == EMPTY) || resp_ready);
        if (can_accept && (req0_valid || req1_valid)) begin
            grant_valid = 1'b1;
            grant_id    = (req0_valid && req1_valid) ? prio_reg : req1_valid;
            prio_next   = ~grant_id;
        end
        req0_ready = grant_valid && !grant_id;
        req1_ready = grant_valid && grant_id;

        case (state_reg)
            EMPTY: if (grant_valid) state_next = FULL;
            FULL: begin
                // A grant while draining refills the slot with no bubble.
                if (grant_valid)     state_next = FULL;
                else if (resp_ready) state_next = EMPTY;
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= EMPTY;
            prio_reg  <= 1'b0;
            id_reg    <= 1'b0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
            if (grant_valid) begin
                id_reg   <= grant_id;
                data_reg <= lu_result;
            end
        end
    end

`ifdef LU_ZERO_FLAG_EN
    logic zero_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            zero_reg <= 1'b0;
        end else if (grant_valid) begin
            zero_reg <= (lu_result == '0);
        end
    end

    assign resp_zero = zero_reg;
`endif

    assign resp_valid = (state_reg == FULL);
    assign resp_id    = id_reg;
    assign resp_data  = data_reg;

endmodule

// File: tb/tb_lu_arbiter.sv
// Self-checking bench for lu_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_lu_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        resp_valid, resp_ready, resp_id;
    logic [31:0] resp_data;
`ifdef LU_ZERO_FLAG_EN
    logic        resp_zero;
    bit          m_zero;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_full;
    bit          m_id;
    logic [31:0] m_data;
    bit          m_prio;
    bit          g_valid, g_id;

    always #5 clk = ~clk;

    lu_arbiter #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
`ifdef LU_ZERO_FLAG_EN
        .resp_zero  (resp_zero),
`endif
        .resp_data  (resp_data)
    );

    function automatic logic [31:0] lu_ref(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Who (if anyone) the spec says wins with the current inputs.
    task automatic compute_grant();
        g_valid = 1'b0;
        g_id    = 1'b0;
        if (!reset && (!m_full || resp_ready) && (req0_valid || req1_valid)) begin
            g_valid = 1'b1;
            g_id    = (req0_valid && req1_valid) ? m_prio : req1_valid;
        end
    endtask

    task automatic drive(input bit v0, input logic [1:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                         input bit v1, input logic [1:0] o1, input logic [31:0] a1, input logic [31:0] b1,
                         input bit rr, input bit rst);
        @(negedge clk);
        req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
        resp_ready = rr; reset = rst;
        #1;
        compute_grant();
    endtask

    task automatic tick();
        logic [31:0] r;
        @(posedge clk);
        if (reset) begin
            m_full = 0; m_id = 0; m_data = '0; m_prio = 0;
`ifdef LU_ZERO_FLAG_EN
            m_zero = 0;
`endif
        end else if (g_valid) begin
            r = g_id ? lu_ref(req1_op, req1_a, req1_b) : lu_ref(req0_op, req0_a, req0_b);
            m_full = 1; m_id = g_id; m_data = r; m_prio = !g_id;
`ifdef LU_ZERO_FLAG_EN
            m_zero = (r == 32'd0);
`endif
        end else if (m_full && resp_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 2'd1, 32'h1, 32'h2, 1, 2'd2, 32'h3, 32'h4, 1, 1);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        tick();
        drive(0, 2'd0, 32'h0, 32'h0, 0, 2'd0, 32'h0, 32'h0, 1, 1);
        tick();
        checks++;
        if ({resp_valid, resp_id, resp_data} !== {1'b0, 1'b0, 32'h0}) begin
            errors++; $display("FAIL reset_state: got v=%b id=%b d=%h want 0/0/0", resp_valid, resp_id, resp_data);
        end
`ifdef LU_ZERO_FLAG_EN
        checks++;
        if (resp_zero !== 1'b0) begin
            errors++; $display("FAIL reset_zero: got %b want 0", resp_zero);
        end
`endif
        $display("test_reset: done");
    endtask

    task automatic test_or();
        drive(1, 2'd1, 32'h0000_F0F0, 32'h0F0F_0000, 0, 2'd0, 32'h0, 32'h0, 1, 0);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL or_ready: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        drive(0, 2'd0, 32'h0, 32'h0, 0, 2'd0, 32'h0, 32'h0, 0, 0);
        checks++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b0, 32'h0F0F_F0F0}) begin
            errors++; $display("FAIL or_result: got v=%b id=%b d=%h want 1/0/0f0ff0f0", resp_valid, resp_id, resp_data);
        end
        $display("test_or: v=%b id=%b d=%h", resp_valid, resp_id, resp_data);
    endtask

    task automatic test_alternate();
        drive(0, 2'd0, 32'h0, 32'h0, 0, 2'd0, 32'h0, 32'h0, 1, 1);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'($urandom), $urandom, $urandom, 1, 2'($urandom), $urandom, $urandom, 1, 0);
            checks++;
            if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL alt_grant[%0d]: got %b want %b", i, {req0_ready, req1_ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            tick();
            checks++;
            if ({resp_valid, resp_id, resp_data} !== {1'b1, (i % 2 == 1), m_data}) begin
                errors++; $display("FAIL alt_resp[%0d]: got v=%b id=%b d=%h want 1/%0d/%h", i, resp_valid, resp_id, resp_data, i % 2, m_data);
            end
            $display("test_alternate[%0d]: id=%b d=%h", i, resp_id, resp_data);
        end
    endtask

    task automatic test_hold();
        logic [31:0] held_data;
        bit          held_id;
        held_data = m_data;
        held_id   = m_id;
        for (int i = 0; i < 5; i++) begin
            drive(1, 2'($urandom), $urandom, $urandom, 1, 2'($urandom), $urandom, $urandom, 0, 0);
            checks++;
            if ({req0_ready, req1_ready} !== 2'b00) begin
                errors++; $display("FAIL hold_ready[%0d]: got %b want 00", i, {req0_ready, req1_ready});
            end
            tick();
            checks++;
            if ({resp_valid, resp_id, resp_data} !== {1'b1, held_id, held_data}) begin
                errors++; $display("FAIL hold_data[%0d]: got v=%b id=%b d=%h want 1/%b/%h", i, resp_valid, resp_id, resp_data, held_id, held_data);
            end
        end
        // Drain and refill in one cycle; prio was left untouched while held.
        drive(1, 2'd2, 32'hAAAA_5555, 32'hFFFF_0000, 1, 2'd0, 32'h1234_5678, 32'h0F0F_0F0F, 1, 0);
        checks++;
        if ({req0_ready, req1_ready} !== (m_prio ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL hold_release: got %b want %b", {req0_ready, req1_ready}, m_prio ? 2'b01 : 2'b10);
        end
        tick();
        checks++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, m_id, m_data}) begin
            errors++; $display("FAIL hold_refill: got v=%b id=%b d=%h want 1/%b/%h", resp_valid, resp_id, resp_data, m_id, m_data);
        end
        $display("test_hold: refill id=%b d=%h", resp_id, resp_data);
    endtask

    task automatic test_nor_zero();
        drive(0, 2'd0, 32'h0, 32'h0, 1, 2'd3, 32'h0, 32'h0, 1, 0);
        tick();
        checks++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b1, 32'hFFFF_FFFF}) begin
            errors++; $display("FAIL nor_result: got v=%b id=%b d=%h want 1/1/ffffffff", resp_valid, resp_id, resp_data);
        end
`ifdef LU_ZERO_FLAG_EN
        checks++;
        if (resp_zero !== 1'b0) begin
            errors++; $display("FAIL nor_zero: got %b want 0", resp_zero);
        end
`endif
        drive(0, 2'd0, 32'h0, 32'h0, 1, 2'd0, 32'hFFFF_0000, 32'h0000_FFFF, 1, 0);
        tick();
        checks++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b1, 32'h0}) begin
            errors++; $display("FAIL and_result: got v=%b id=%b d=%h want 1/1/0", resp_valid, resp_id, resp_data);
        end
`ifdef LU_ZERO_FLAG_EN
        checks++;
        if (resp_zero !== 1'b1) begin
            errors++; $display("FAIL and_zero: got %b want 1", resp_zero);
        end
`endif
        $display("test_nor_zero: d=%h", resp_data);
    endtask

    task automatic test_reset_mid();
        // Port 1 wins to leave prio pointing at port 0... then hold full.
        drive(0, 2'd0, 32'h0, 32'h0, 1, 2'd1, 32'h55, 32'hAA, 1, 0);
        tick();
        drive(1, 2'd1, 32'h1, 32'h1, 1, 2'd1, 32'h2, 32'h2, 0, 1);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL mid_reset_ready: got %b want 00", {req0_ready, req1_ready});
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_valid: got %b want 0", resp_valid);
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 2'd0, 32'h0, 32'h0, 0, 2'd0, 32'h0, 32'h0, 1, 0);
            tick();
            checks++;
            if (resp_valid !== 1'b0) begin
                errors++; $display("FAIL mid_reset_stale[%0d]: got %b want 0", i, resp_valid);
            end
        end
        // prio is back to 0, so port 0 wins a tie.
        drive(1, 2'd2, 32'hF0, 32'h0F, 1, 2'd0, 32'h3, 32'h3, 1, 0);
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL mid_reset_prio: got %b want 10", {req0_ready, req1_ready});
        end
        tick();
        checks++;
        if ({resp_valid, resp_id, resp_data} !== {1'b1, 1'b0, 32'hFF}) begin
            errors++; $display("FAIL mid_reset_after: got v=%b id=%b d=%h want 1/0/ff", resp_valid, resp_id, resp_data);
        end
        $display("test_reset_mid: done");
    endtask

    task automatic test_random();
        bit          v0 = 0, v1 = 0;
        logic [1:0]  o0 = 0, o1 = 0;
        logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
        bit          rr;
        for (int i = 0; i < 300; i++) begin
            // A pending request stays unchanged until it is accepted.
            if (!(v0 && !(g_valid && !g_id)) || i == 0) begin
                v0 = ($urandom_range(0, 3) != 0); o0 = 2'($urandom); a0 = $urandom; b0 = $urandom;
            end
            if (!(v1 && !(g_valid && g_id)) || i == 0) begin
                v1 = ($urandom_range(0, 3) != 0); o1 = 2'($urandom); a1 = $urandom; b1 = $urandom;
            end
            rr = ($urandom_range(0, 2) != 0);
            drive(v0, o0, a0, b0, v1, o1, a1, b1, rr, 0);
            checks++;
            if ({req0_ready, req1_ready} !== {g_valid && !g_id, g_valid && g_id}) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, {req0_ready, req1_ready}, {g_valid && !g_id, g_valid && g_id});
            end
            tick();
            checks++;
            if ({resp_valid, resp_id, resp_data} !== {m_full, m_id, m_data}) begin
                errors++; $display("FAIL rand_resp[%0d]: got v=%b id=%b d=%h want %b/%b/%h", i, resp_valid, resp_id, resp_data, m_full, m_id, m_data);
            end
`ifdef LU_ZERO_FLAG_EN
            checks++;
            if (resp_zero !== m_zero) begin
                errors++; $display("FAIL rand_zero[%0d]: got %b want %b", i, resp_zero, m_zero);
            end
`endif
        end
        $display("test_random: 300 cycles");
    endtask

    initial begin
        reset = 1; resp_ready = 0;
        req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
        m_full = 0; m_id = 0; m_data = '0; m_prio = 0;
        g_valid = 0; g_id = 0;
`ifdef LU_ZERO_FLAG_EN
        m_zero = 0;
`endif
        test_reset();
        test_or();
        test_alternate();
        test_hold();
        test_nor_zero();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
